// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
// Digit-serial packed-BCD adder. It latches both operands and the carry-in on
// an accepted start, then adds one decimal digit per clock, least-significant
// digit first, using binary add plus a +6 correction when the digit sum
// exceeds 9.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous, active-high reset; aborts any operation in flight
//   start   - request pulse, only looked at while idle
//   a, b    - packed BCD operands, digit 0 in bits [3:0]
//   cin     - carry into digit 0
//   busy    - high while digits are being summed
//   done    - one-cycle pulse once sum/cout/invalid are final
//   sum     - packed BCD result, held until the next accepted start
//   cout    - carry out of the most-significant digit
//   invalid - sticky flag: an operand digit above 9 was seen in this operation
//
// state | meaning
// IDLE  | waiting for start, results held
// ADD   | summing digit idx this cycle
// FIN   | results final, done pulse
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]          state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [4*DIGITS-1:0] a_q;
  logic [4*DIGITS-1:0] b_q;

  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [5:0] t;
  logic [3:0] dig_out;
  logic       carry_nxt;
  logic       dig_bad;

  // Worst case 15+15+1 = 31, so 6 bits never overflow. The +6 correction is
  // done in 4 bits because only the low nibble of (t+6) is kept.
  always_comb begin
    a_dig     = a_q[4*idx +: 4];
    b_dig     = b_q[4*idx +: 4];
    t         = {2'b00, a_dig} + {2'b00, b_dig} + {5'b0, carry};
    carry_nxt = (t > 6'd9);
    dig_out   = carry_nxt ? (t[3:0] + 4'd6) : t[3:0];
    dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
  end

  assign busy = (state == ADD);
  assign done = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry   <= cin;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
            idx     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          sum[4*idx +: 4] <= dig_out;
          carry           <= carry_nxt;
          if (dig_bad) invalid <= 1'b1;
          if (idx == LAST_IDX) begin
            cout  <= carry_nxt;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic                cin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] sum;
  logic                cout;
  logic                invalid;

  int passed = 0;
  int total  = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Waits for the next rising edge and then samples 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation and checks the exact busy/done timeline.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic [15:0] exp_sum, input logic exp_cout,
                       input logic exp_inv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= DIGITS; k++) begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
      tick();
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_lo"}, busy, 1'b0);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_inv"}, invalid, exp_inv);
    tick();
    check({tag, "_done_1cyc"}, done, 1'b0);
    check({tag, "_sum_held"}, sum, exp_sum);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 16'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_inv", invalid, 1'b0);

    // rst and start together: rst wins
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    tick();
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    tick();
    check("rst_wins_busy", busy, 1'b0);

    do_op("basic", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    do_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("max", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    // digit1: 10+0 -> 0 carry 1; digit2: 0+0+1 -> 1
    do_op("bad", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
    do_op("clr_inv", 16'h0042, 16'h0013, 1'b1, 16'h0056, 1'b0, 1'b0);

    // Start and operand changes while busy are ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= DIGITS + 4; k++) begin
      if (k == 2) begin
        a = 16'h4444; b = 16'h3333; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("ign_sum", sum, 16'h6912);
        check("ign_cout", cout, 1'b0);
      end
      tick();
    end
    start = 1'b0;
    check("ign_one_done", done_cnt, 1);
    check("ign_idle", busy, 1'b0);

    // Reset in cycle 3 aborts the operation.
    @(negedge clk);
    a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 16'h0);
    check("abort_cout", cout, 1'b0);
    check("abort_inv", invalid, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < DIGITS + 2; k++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check("abort_quiet", done_cnt, 0);

    do_op("after_rst", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
